// File: rtl/gpu_mem_arbiter_pkg.sv
// rtl/gpu_mem_arbiter_pkg.sv - shared widths, arbiter state encoding and index helper
package gpu_mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gpu_mem_arbiter_if.sv
// rtl/gpu_mem_arbiter_if.sv - client and memory valid/ready channels of the arbiter
interface gpu_mem_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ADDR_WIDTH   = gpu_mem_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH   = gpu_mem_arbiter_pkg::DATA_WIDTH
);

  logic [NUM_CHANNELS-1:0]            c_req_vld;
  logic [NUM_CHANNELS-1:0]            c_req_rdy;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] c_req_addr;
  logic [NUM_CHANNELS-1:0]            c_rsp_vld;
  logic [NUM_CHANNELS-1:0]            c_rsp_rdy;
  logic [DATA_WIDTH-1:0]              c_rsp_data;
  logic                               m_req_vld;
  logic                               m_req_rdy;
  logic [ADDR_WIDTH-1:0]              m_req_addr;
  logic                               m_rsp_vld;
  logic                               m_rsp_rdy;
  logic [DATA_WIDTH-1:0]              m_rsp_data;

  modport slave (
    input  c_req_vld, c_req_addr, c_rsp_rdy, m_req_rdy, m_rsp_vld, m_rsp_data,
    output c_req_rdy, c_rsp_vld, c_rsp_data, m_req_vld, m_req_addr, m_rsp_rdy
  );

  modport master (
    output c_req_vld, c_req_addr, c_rsp_rdy, m_req_rdy, m_rsp_vld, m_rsp_data,
    input  c_req_rdy, c_rsp_vld, c_rsp_data, m_req_vld, m_req_addr, m_rsp_rdy
  );

endinterface

// File: rtl/gpu_mem_arbiter_rr_arbiter.sv
// rtl/gpu_mem_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_vld,
  output logic [CH_W-1:0] gnt_idx
);

  // Scan farthest offset first so the closest requester at or after ptr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/gpu_mem_arbiter.sv
// rtl/gpu_mem_arbiter.sv - round-robin share of one memory port, one transaction in flight
module gpu_mem_arbiter
  import gpu_mem_arbiter_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int ADDR_WIDTH   = gpu_mem_arbiter_pkg::ADDR_WIDTH,
  parameter  int DATA_WIDTH   = gpu_mem_arbiter_pkg::DATA_WIDTH,
  localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic              clk,
  input  logic              rst_n,
  gpu_mem_arbiter_if.slave  bus,
  output logic              busy,
  output logic [CH_W-1:0]   owner
);

  arb_state_e             r_state;
  arb_state_e             w_next_state;
  logic [CH_W-1:0]        r_rr_ptr;
  logic [CH_W-1:0]        r_owner;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;

  logic                    w_gnt_vld;
  logic [CH_W-1:0]         w_gnt_idx;
  logic [ADDR_WIDTH-1:0]   w_gnt_addr;
  logic [NUM_CHANNELS-1:0] w_c_req_rdy;
  logic [NUM_CHANNELS-1:0] w_c_rsp_vld;
  logic                    w_m_req_vld;
  logic                    w_m_rsp_rdy;

  rr_arbiter #(.N(NUM_CHANNELS)) u_rr (
    .req     (bus.c_req_vld),
    .ptr     (r_rr_ptr),
    .gnt_vld (w_gnt_vld),
    .gnt_idx (w_gnt_idx)
  );

  assign w_gnt_addr = bus.c_req_addr[int'(w_gnt_idx) * ADDR_WIDTH +: ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_gnt_vld) begin
        r_owner <= w_gnt_idx;
        r_addr  <= w_gnt_addr;
      end
      if (r_state == WAIT_RSP && bus.m_rsp_vld) begin
        r_data <= bus.m_rsp_data;
      end
      if (r_state == DELIVER && bus.c_rsp_rdy[r_owner]) begin
        r_rr_ptr <= CH_W'(wrap_inc(int'(r_owner), NUM_CHANNELS));
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_c_req_rdy  = '0;
    w_c_rsp_vld  = '0;
    w_m_req_vld  = 1'b0;
    w_m_rsp_rdy  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_c_req_rdy[w_gnt_idx] = 1'b1;
          w_next_state           = ISSUE;
        end
      end
      ISSUE: begin
        w_m_req_vld = 1'b1;
        if (bus.m_req_rdy) w_next_state = WAIT_RSP;
      end
      WAIT_RSP: begin
        w_m_rsp_rdy = 1'b1;
        if (bus.m_rsp_vld) w_next_state = DELIVER;
      end
      DELIVER: begin
        w_c_rsp_vld[r_owner] = 1'b1;
        if (bus.c_rsp_rdy[r_owner]) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The grant path is combinational from client valids, so hold it off while reset is asserted.
  assign bus.c_req_rdy  = w_c_req_rdy & {NUM_CHANNELS{rst_n}};
  assign bus.c_rsp_vld  = w_c_rsp_vld;
  assign bus.c_rsp_data = r_data;
  assign bus.m_req_vld  = w_m_req_vld;
  assign bus.m_req_addr = r_addr;
  assign bus.m_rsp_rdy  = w_m_rsp_rdy;
  assign busy           = (r_state != IDLE);
  assign owner          = r_owner;

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb/tb_gpu_mem_arbiter.sv - randomized and directed scoreboard bench for gpu_mem_arbiter
module tb_gpu_mem_arbiter;
  import gpu_mem_arbiter_pkg::*;

  localparam int NC = 4;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(NC);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic [CW-1:0] owner;

  gpu_mem_arbiter_if #(.NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  gpu_mem_arbiter #(.NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus knobs
  logic [NC-1:0] rand_en = '0;
  logic [NC-1:0] persist = '0;
  int            mreq_pct = 100;
  int            crsp_pct = 100;
  int            req_stall = 0;
  int            rsp_stall = 0;
  int            dly_lo = 0;
  int            dly_hi = 0;
  bit            fixed_en = 1'b0;
  logic [DW-1:0] fixed_data = '0;
  bit            mem_block = 1'b0;
  bit            mem_pend = 1'b0;
  int            mem_cnt = 0;
  int            mv_cnt = 0;
  int            rv_cnt = 0;

  // reference model state (owned by the monitor)
  int            model_ptr = 0;
  bit            model_busy = 1'b0;
  int            model_owner = 0;
  int            gnt_count = 0;
  logic [AW-1:0] exp_req[$];
  int            exp_rsp_ch[$];
  logic [DW-1:0] exp_rsp_data[$];
  int            exp_order[$];
  bit            prev_mreq_wait = 1'b0;
  logic [AW-1:0] prev_mreq_addr = '0;
  bit            prev_crsp_wait = 1'b0;
  logic [NC-1:0] prev_crsp_vld = '0;
  logic [DW-1:0] prev_crsp_data = '0;
  bit            prev_grant = 1'b0;
  logic [AW-1:0] prev_grant_addr = '0;
  bit            prev_mrsp_x = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int pick(input logic [NC-1:0] v, input int p);
    for (int k = 0; k < NC; k++) begin
      if (v[(p + k) % NC]) return (p + k) % NC;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int ch);
    return bus.c_req_addr[ch*AW +: AW];
  endfunction

  always @(negedge clk) begin
    logic [NC-1:0] exp_rdy;
    logic [NC-1:0] one;
    int            w;
    one = 1;
    if (!rst_n) begin
      chk(bus.c_req_rdy == 0 && bus.c_rsp_vld == 0 && !bus.m_req_vld && !bus.m_rsp_rdy &&
          !busy && owner == 0 && bus.m_req_addr == 0 && bus.c_rsp_data == 0, "reset_outputs",
          {bus.c_req_rdy, bus.c_rsp_vld, bus.m_req_vld, bus.m_rsp_rdy, busy, owner, bus.m_req_addr}, 0);
      exp_req.delete(); exp_rsp_ch.delete(); exp_rsp_data.delete();
      model_ptr = 0; model_busy = 1'b0; model_owner = 0;
      prev_mreq_wait = 1'b0; prev_crsp_wait = 1'b0; prev_grant = 1'b0; prev_mrsp_x = 1'b0;
    end else begin
      exp_rdy = '0;
      w = model_busy ? -1 : pick(bus.c_req_vld, model_ptr);
      if (w >= 0) exp_rdy = one << w;
      chk(bus.c_req_rdy == exp_rdy, "grant_vector", bus.c_req_rdy, exp_rdy);
      chk(busy == model_busy, "busy", busy, model_busy);
      if (model_busy) chk(int'(owner) == model_owner, "owner", owner, model_owner);

      if (prev_grant) chk(bus.m_req_vld && bus.m_req_addr == prev_grant_addr, "issue_latency",
                          {bus.m_req_vld, bus.m_req_addr}, {1'b1, prev_grant_addr});
      if (prev_mrsp_x) chk(bus.c_rsp_vld == (one << model_owner), "deliver_latency",
                           bus.c_rsp_vld, one << model_owner);
      if (prev_mreq_wait) chk(bus.m_req_vld && bus.m_req_addr == prev_mreq_addr, "m_req_hold",
                              {bus.m_req_vld, bus.m_req_addr}, {1'b1, prev_mreq_addr});
      if (prev_crsp_wait) chk(bus.c_rsp_vld == prev_crsp_vld && bus.c_rsp_data == prev_crsp_data,
                              "c_rsp_hold", {bus.c_rsp_vld, bus.c_rsp_data}, {prev_crsp_vld, prev_crsp_data});
      if (bus.m_rsp_rdy) chk(bus.c_rsp_vld == 0 && !bus.m_req_vld && bus.c_req_rdy == 0, "rsp_rdy_exclusive",
                             {bus.c_rsp_vld, bus.m_req_vld, bus.c_req_rdy}, 0);
      if (bus.m_rsp_vld) chk(bus.m_rsp_rdy, "m_rsp_protocol", bus.m_rsp_rdy, 1);

      prev_grant = 1'b0;
      if (w >= 0) begin
        model_busy  = 1'b1;
        model_owner = w;
        exp_req.push_back(addr_of(w));
        prev_grant      = 1'b1;
        prev_grant_addr = addr_of(w);
        gnt_count++;
        if (exp_order.size() > 0) begin
          int e;
          e = exp_order.pop_front();
          chk(w == e, "grant_order", w, e);
        end
      end

      if (bus.m_req_vld && bus.m_req_rdy) begin
        if (exp_req.size() == 0) chk(1'b0, "m_req_unexpected", bus.m_req_addr, 0);
        else begin
          logic [AW-1:0] ea;
          ea = exp_req.pop_front();
          chk(bus.m_req_addr == ea, "m_req_addr", bus.m_req_addr, ea);
        end
      end
      prev_mreq_wait = bus.m_req_vld && !bus.m_req_rdy;
      prev_mreq_addr = bus.m_req_addr;

      prev_mrsp_x = bus.m_rsp_vld && bus.m_rsp_rdy;
      if (prev_mrsp_x) begin
        exp_rsp_ch.push_back(model_owner);
        exp_rsp_data.push_back(bus.m_rsp_data);
      end

      if (bus.c_rsp_vld != 0) begin
        if (exp_rsp_ch.size() == 0) chk(1'b0, "c_rsp_unexpected", bus.c_rsp_vld, 0);
        else begin
          chk(bus.c_rsp_vld == (one << exp_rsp_ch[0]), "c_rsp_route", bus.c_rsp_vld, one << exp_rsp_ch[0]);
          if ((bus.c_rsp_vld & bus.c_rsp_rdy) != 0) begin
            chk(bus.c_rsp_data == exp_rsp_data[0], "c_rsp_data", bus.c_rsp_data, exp_rsp_data[0]);
            model_ptr  = (exp_rsp_ch[0] + 1) % NC;
            model_busy = 1'b0;
            void'(exp_rsp_ch.pop_front());
            void'(exp_rsp_data.pop_front());
          end
        end
      end
      prev_crsp_wait = (bus.c_rsp_vld != 0) && ((bus.c_rsp_vld & bus.c_rsp_rdy) == 0);
      prev_crsp_vld  = bus.c_rsp_vld;
      prev_crsp_data = bus.c_rsp_data;
    end
  end

  task automatic step();
    logic [NC-1:0] acc;
    bit            mreq_x, mrsp_x, mv, rv;
    @(negedge clk);
    acc    = bus.c_req_vld & bus.c_req_rdy;
    mreq_x = bus.m_req_vld && bus.m_req_rdy;
    mrsp_x = bus.m_rsp_vld && bus.m_rsp_rdy;
    mv     = bus.m_req_vld;
    rv     = (bus.c_rsp_vld != 0) && ((bus.c_rsp_vld & bus.c_rsp_rdy) == 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (acc[i] && !persist[i]) bus.c_req_vld[i] = 1'b0;
      if (!bus.c_req_vld[i] && rand_en[i] && $urandom_range(0, 3) == 0) begin
        bus.c_req_vld[i]          = 1'b1;
        bus.c_req_addr[i*AW +: AW] = AW'($urandom);
      end
    end
    mv_cnt = (mv && !mreq_x) ? mv_cnt + 1 : 0;
    rv_cnt = rv ? rv_cnt + 1 : 0;
    bus.m_req_rdy = (mv_cnt >= req_stall) && ($urandom_range(0, 99) < mreq_pct);
    for (int i = 0; i < NC; i++) bus.c_rsp_rdy[i] = (rv_cnt >= rsp_stall) && ($urandom_range(0, 99) < crsp_pct);
    if (mrsp_x) bus.m_rsp_vld = 1'b0;
    if (mreq_x) begin
      mem_pend = 1'b1;
      mem_cnt  = $urandom_range(dly_lo, dly_hi);
    end else if (mem_pend && !bus.m_rsp_vld && !mem_block) begin
      if (mem_cnt == 0) begin
        bus.m_rsp_vld  = 1'b1;
        bus.m_rsp_data = fixed_en ? fixed_data : DW'($urandom);
        mem_pend       = 1'b0;
      end else mem_cnt--;
    end
  endtask

  task automatic run_quiet(input int max, input string name);
    int n = 0;
    while ((bus.c_req_vld != 0 || model_busy || mem_pend || bus.m_rsp_vld) && n < max) begin
      step();
      n++;
    end
    chk(n < max, name, n, max);
    chk(exp_order.size() == 0, {name, "_order_left"}, exp_order.size(), 0);
  endtask

  task automatic request(input int ch, input logic [AW-1:0] a);
    bus.c_req_vld[ch]          = 1'b1;
    bus.c_req_addr[ch*AW +: AW] = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g0, n;
    bus.c_req_vld  = '1;
    bus.c_req_addr = '0;
    bus.c_rsp_rdy  = '1;
    bus.m_req_rdy  = 1'b1;
    bus.m_rsp_vld  = 1'b0;
    bus.m_rsp_data = '0;
    repeat (3) step();
    bus.c_req_vld = '0;
    step();
    rst_n = 1'b1;

    // all four continuously requesting from rr_ptr 0
    persist = '1;
    for (int i = 0; i < NC; i++) request(i, AW'(32 + i));
    exp_order = '{0, 1, 2, 3, 0};
    g0 = gnt_count;
    n = 0;
    while (gnt_count < g0 + 5 && n < 200) begin step(); n++; end
    chk(n < 200, "rr_all_timeout", n, 200);
    bus.c_req_vld = '0;
    persist = '0;
    run_quiet(100, "rr_all");

    // single ch2 request, data after 3 cycles
    fixed_en = 1'b1; fixed_data = DW'(8'hAB); dly_lo = 3; dly_hi = 3;
    exp_order.push_back(2);
    request(2, AW'(16));
    run_quiet(50, "single_ch2");

    // memory stalls request acceptance for 5 cycles
    dly_lo = 0; dly_hi = 0; req_stall = 5;
    exp_order.push_back(3);
    request(3, AW'(16'h0033));
    run_quiet(50, "mreq_stall");
    req_stall = 0;

    // ch1 holds its response off for 4 cycles while ch2 waits
    rsp_stall = 4; fixed_data = DW'(8'h5A);
    exp_order = '{1, 2};
    request(1, AW'(16'h0111));
    request(2, AW'(16'h0222));
    run_quiet(80, "crsp_stall");
    rsp_stall = 0; fixed_en = 1'b0;

    // rr_ptr is 3: ch3 then wrap to ch0
    exp_order = '{3, 0};
    request(0, AW'(16'h0A00));
    request(3, AW'(16'h0A03));
    run_quiet(80, "ptr_wrap");

    // move rr_ptr to 3, then reset while waiting on memory
    exp_order.push_back(2);
    request(2, AW'(16'h0B02));
    run_quiet(50, "pre_reset");
    mem_block = 1'b1;
    exp_order.push_back(0);
    request(0, AW'(16'h0C00));
    n = 0;
    while (!bus.m_rsp_rdy && n < 50) begin step(); n++; end
    chk(n < 50, "reach_wait_rsp", n, 50);
    rst_n = 1'b0;
    bus.c_req_vld = '0; bus.m_rsp_vld = 1'b0; mem_pend = 1'b0; mem_block = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    exp_order = '{1, 3};
    request(1, AW'(16'h0D01));
    request(3, AW'(16'h0D03));
    run_quiet(80, "post_reset");

    // randomized traffic
    rand_en = '1;
    for (int blk = 0; blk < 12; blk++) begin
      mreq_pct = $urandom_range(30, 100);
      crsp_pct = $urandom_range(30, 100);
      dly_lo = 0; dly_hi = $urandom_range(0, 5);
      repeat (50) step();
    end
    rand_en = '0;
    mreq_pct = 100; crsp_pct = 100;
    run_quiet(200, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
